// File: rtl/cpu_step_ctrl.sv
// Clock-enable scheduler for the single-cycle core: RUN/STEP/HALT and an optional BREAK state.
// Define BREAKPOINT_EN to build the PC breakpoint compare and the BREAK state.
module cpu_step_ctrl #(
    parameter int CNT_W     = 26,
    parameter int DIV_SLOW  = 49999999,
    parameter int DIV_MED   = 4999999,
    parameter int DIV_FAST  = 99999,
    parameter int DB_CYCLES = 1000000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RunSw,
    input  logic        StepBtn,
    input  logic [1:0]  DivSel,
    input  logic        BrkEn,
    input  logic [31:0] BrkAddr,
    input  logic [31:0] PC,
    output logic        CpuEn,
    output logic        Halted,
    output logic        BrkHit,
    output logic [2:0]  State,
    output logic [15:0] StepCount
);

    typedef enum logic [2:0] {
        S_HALT     = 3'd0,
        S_RUN      = 3'd1,
        S_STEP     = 3'd2,
        S_WAIT_REL = 3'd3,
        S_BREAK    = 3'd4
    } state_t;

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'(DIV_FAST);
    localparam logic [CNT_W-1:0] LIM_MED  = CNT_W'(DIV_MED);
    localparam logic [CNT_W-1:0] LIM_SLOW = CNT_W'(DIV_SLOW);

    state_t            state_q, state_d;
    logic              runsw_s1_q, runsw_s2_q;
    logic              btn_s1_q, btn_s2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_btn_q, db_btn_d;
    logic              db_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]  limit;
    logic              tick;
    logic              step_edge;
    logic              brk_cond;
    logic              cpu_en;

`ifdef BREAKPOINT_EN
    assign brk_cond = BrkEn && (PC == BrkAddr);
    assign BrkHit   = (state_q == S_BREAK);
`else
    logic unused_brk;
    assign unused_brk = ^{BrkEn, BrkAddr, PC};
    assign brk_cond   = 1'b0;
    assign BrkHit     = 1'b0;
`endif

    // Level changes only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d = '0;
        db_btn_d = db_btn_q;
        if (btn_s2_q != db_btn_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1))
                db_btn_d = btn_s2_q;
            else
                db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign step_edge = db_btn_q & ~db_prev_q;

    always_comb begin
        case (DivSel)
            2'd0:    limit = LIM_FAST;
            2'd1:    limit = LIM_MED;
            2'd2:    limit = LIM_SLOW;
            default: limit = '0;
        endcase
    end

    // A counter already past a newly selected smaller limit restarts without ticking.
    always_comb begin
        tick  = 1'b0;
        cnt_d = '0;
        if (state_q == S_RUN) begin
            if (DivSel == 2'd3)
                tick = 1'b1;
            else if (cnt_q == limit)
                tick = 1'b1;
            else if (cnt_q < limit)
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        case (state_q)
            S_HALT: begin
                if (runsw_s2_q)
                    state_d = S_RUN;
                else if (step_edge)
                    state_d = S_STEP;
            end
            S_RUN: begin
                if (!runsw_s2_q)
                    state_d = S_HALT;
                else if (brk_cond)
                    state_d = S_BREAK;
                else
                    cpu_en = tick;
            end
            S_STEP: begin
                cpu_en  = 1'b1;
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!db_btn_q)
                    state_d = S_HALT;
            end
            S_BREAK: begin
                if (!runsw_s2_q)
                    state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Reset suppresses a pulse in the same cycle it is asserted.
    assign CpuEn      = cpu_en & ~Rst;
    assign step_cnt_d = step_cnt_q + 16'(cpu_en);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_HALT;
            runsw_s1_q <= 1'b0;
            runsw_s2_q <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            db_cnt_q   <= '0;
            db_btn_q   <= 1'b0;
            db_prev_q  <= 1'b0;
            cnt_q      <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            runsw_s1_q <= RunSw;
            runsw_s2_q <= runsw_s1_q;
            btn_s1_q   <= StepBtn;
            btn_s2_q   <= btn_s1_q;
            db_cnt_q   <= db_cnt_d;
            db_btn_q   <= db_btn_d;
            db_prev_q  <= db_btn_q;
            cnt_q      <= cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign State     = state_q;
    assign Halted    = (state_q == S_HALT) || (state_q == S_WAIT_REL) || (state_q == S_BREAK);
    assign StepCount = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: run-rate table, step/debounce, RunSw timing, breakpoint and wrap sequences.
module tb_cpu_step_ctrl;

    logic        Clk, Rst, RunSw, StepBtn, BrkEn;
    logic [1:0]  DivSel;
    logic [31:0] BrkAddr, pc;
    logic        CpuEn, Halted, BrkHit;
    logic [2:0]  State;
    logic [15:0] StepCount;

    cpu_step_ctrl #(
        .CNT_W(26), .DIV_SLOW(15), .DIV_MED(7), .DIV_FAST(3), .DB_CYCLES(4)
    ) dut (
        .Clk(Clk), .Rst(Rst), .RunSw(RunSw), .StepBtn(StepBtn), .DivSel(DivSel),
        .BrkEn(BrkEn), .BrkAddr(BrkAddr), .PC(pc), .CpuEn(CpuEn), .Halted(Halted),
        .BrkHit(BrkHit), .State(State), .StepCount(StepCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Processor stand-in: PC advances by one instruction per enable.
    always @(posedge Clk) begin
        if (Rst) pc <= 32'h0;
        else if (CpuEn) pc <= pc + 32'd4;
    end

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int seen = 0;
    logic [15:0] sc_model = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each enable pulse must match the next expected cycle number.
    always @(negedge Clk) begin
        if (CpuEn === 1'b1) begin
            seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                chk("pulse_cycle", 32'(cyc), 32'(exp_q.pop_front()));
            end
            chk("stepcount_at_pulse", 32'(StepCount), 32'(sc_model));
            sc_model = sc_model + 16'd1;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        RunSw = 1'b0;
        StepBtn = 1'b0;
        #1;
        chk("cpuen_in_reset", 32'(CpuEn), 32'd0);
        tick();
        tick();
        Rst = 1'b0;
        chk("pending_pulses", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        sc_model = 16'd0;
    endtask

    typedef struct {
        logic [1:0] div;
        int         lim;
        int         n;
        int         exp_pulses;
    } vec_t;

    vec_t tbl[4];
    int   s, seen0;
    logic [15:0] sc_before;

    initial begin
        tbl[0] = '{div: 2'd0, lim: 3,  n: 40, exp_pulses: 9};
        tbl[1] = '{div: 2'd1, lim: 7,  n: 30, exp_pulses: 3};
        tbl[2] = '{div: 2'd2, lim: 15, n: 40, exp_pulses: 2};
        tbl[3] = '{div: 2'd3, lim: 0,  n: 10, exp_pulses: 9};

        Rst = 1'b1; RunSw = 1'b0; StepBtn = 1'b0; DivSel = 2'd0;
        BrkEn = 1'b0; BrkAddr = 32'h0;
        do_reset();
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_cpuen", 32'(CpuEn), 32'd0);
        chk("reset_halted", 32'(Halted), 32'd1);
        chk("reset_brkhit", 32'(BrkHit), 32'd0);
        chk("reset_stepcount", 32'(StepCount), 32'd0);

        // Rate table: RUN reached 3 edges after RunSw, tick on cnt==limit, last pulse before RunSwS drops.
        for (int i = 0; i < 4; i++) begin
            s = cyc;
            seen0 = seen;
            RunSw = 1'b1;
            DivSel = tbl[i].div;
            for (int t = s + 3 + tbl[i].lim; t <= s + tbl[i].n + 1; t += tbl[i].lim + 1)
                exp_q.push_back(t);
            repeat (tbl[i].n) tick();
            RunSw = 1'b0;
            repeat (3) tick();
            chk("halt_after_run", 32'(State), 32'd0);
            chk("run_pulse_count", 32'(seen - seen0), 32'(tbl[i].exp_pulses));
            chk("run_pending", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        // DivSel slow->fast while cnt=5 exceeds the new limit: restart at 0, no tick.
        s = cyc;
        RunSw = 1'b1; DivSel = 2'd2;
        repeat (8) tick();
        DivSel = 2'd0;
        exp_q.push_back(s + 12); exp_q.push_back(s + 16); exp_q.push_back(s + 20);
        repeat (12) tick();
        RunSw = 1'b0;
        repeat (3) tick();
        chk("divchange_halt", 32'(State), 32'd0);
        chk("divchange_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // RunSw drop lands on the tick cycle: no pulse, HALT on the 3rd edge.
        s = cyc;
        RunSw = 1'b1; DivSel = 2'd2;
        repeat (16) tick();
        RunSw = 1'b0;
        repeat (2) tick();
        chk("runsw_drop_still_run", 32'(State), 32'd1);
        tick();
        chk("runsw_drop_halt", 32'(State), 32'd0);

        // Bounced press (2 cycles), then stable high for 10, then release.
        s = cyc;
        sc_before = sc_model;
        StepBtn = 1'b1;
        repeat (2) tick();
        StepBtn = 1'b0;
        repeat (2) tick();
        StepBtn = 1'b1;
        exp_q.push_back(s + 11);
        repeat (6) tick();
        chk("step_not_yet", 32'(State), 32'd0);
        tick();
        chk("step_state", 32'(State), 32'd2);
        chk("step_cpuen", 32'(CpuEn), 32'd1);
        tick();
        chk("wait_rel_state", 32'(State), 32'd3);
        chk("wait_rel_halted", 32'(Halted), 32'd1);
        chk("step_count_inc", 32'(StepCount), 32'(sc_before + 16'd1));
        repeat (2) tick();
        StepBtn = 1'b0;
        repeat (6) tick();
        chk("wait_rel_hold", 32'(State), 32'd3);
        tick();
        chk("release_halt", 32'(State), 32'd0);
        chk("step_pending", 32'(exp_q.size()), 32'd0);

        // Breakpoint at 0x10 with one instruction per cycle.
        do_reset();
        BrkEn = 1'b1; BrkAddr = 32'h10;
        s = cyc;
        RunSw = 1'b1; DivSel = 2'd3;
`ifdef BREAKPOINT_EN
        for (int t = s + 3; t <= s + 6; t++) exp_q.push_back(t);
        repeat (8) tick();
        chk("break_state", 32'(State), 32'd4);
        chk("break_brkhit", 32'(BrkHit), 32'd1);
        chk("break_halted", 32'(Halted), 32'd1);
        chk("break_pc", pc, 32'h10);
        RunSw = 1'b0;
        repeat (3) tick();
        chk("break_exit_halt", 32'(State), 32'd0);
        chk("break_exit_brkhit", 32'(BrkHit), 32'd0);
        s = cyc;
        StepBtn = 1'b1;
        exp_q.push_back(s + 7);
        repeat (10) tick();
        StepBtn = 1'b0;
        repeat (7) tick();
        chk("break_step_halt", 32'(State), 32'd0);
        chk("break_step_pc", pc, 32'h14);
        s = cyc;
        RunSw = 1'b1;
        for (int t = s + 3; t <= s + 6; t++) exp_q.push_back(t);
        repeat (5) tick();
        chk("resume_run", 32'(State), 32'd1);
        RunSw = 1'b0;
        repeat (3) tick();
        chk("resume_halt", 32'(State), 32'd0);
`else
        for (int t = s + 3; t <= s + 9; t++) exp_q.push_back(t);
        repeat (8) tick();
        chk("nobrk_state", 32'(State), 32'd1);
        chk("nobrk_brkhit", 32'(BrkHit), 32'd0);
        RunSw = 1'b0;
        repeat (3) tick();
        chk("nobrk_halt", 32'(State), 32'd0);
`endif
        chk("brk_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        BrkEn = 1'b0;

        // Reset in the middle of every-cycle RUN kills that cycle's pulse.
        s = cyc;
        RunSw = 1'b1; DivSel = 2'd3;
        for (int t = s + 3; t <= s + 5; t++) exp_q.push_back(t);
        repeat (6) tick();
        do_reset();
        chk("midrun_reset_state", 32'(State), 32'd0);
        chk("midrun_reset_count", 32'(StepCount), 32'd0);

        // 65537 pulses: StepCount passes 0xFFFF, wraps to 0, ends at 1.
        s = cyc;
        seen0 = seen;
        RunSw = 1'b1; DivSel = 2'd3;
        for (int t = s + 3; t <= s + 65539; t++) exp_q.push_back(t);
        repeat (65538) tick();
        RunSw = 1'b0;
        repeat (3) tick();
        chk("wrap_halt", 32'(State), 32'd0);
        chk("wrap_pulses", 32'(seen - seen0), 32'd65537);
        chk("wrap_stepcount", 32'(StepCount), 32'd1);
        chk("wrap_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
